mips_exec_arith: RTL and testbench
==================================

# mips_exec_arith

Combinational execute-stage arithmetic of the single-cycle MIPS core: the PC incrementer (PC+4), the branch-target adder, and the 32-bit ALU with zero flag. It also contains the 2-bit display scan counter (CNT2 function) that drives the seven-segment digit multiplexer. It sits between the register bank and sign-extender on the input side, and the PC-select muxes, data memory and display logic on the output side.

## Interface
- No parameters; all widths fixed (32-bit datapath, 4-bit ALU opcode, 2-bit scan count).
- clk  input  1  system clock; the only clock; the counter updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- pc  input  32  current program counter.
- imm_sext  input  32  sign-extended 16-bit immediate.
- alu_a  input  32  ALU operand A (register rs).
- alu_b  input  32  ALU operand B (rt or immediate, selected upstream).
- alu_op  input  4  ALU operation select.
- scan_tick  input  1  one-cycle enable pulse from the display clock divider.
- pc_plus4  output  32  pc + 4.
- branch_target  output  32  pc_plus4 + (imm_sext << 2).
- alu_result  output  32  ALU result.
- alu_zero  output  1  high when alu_result == 0.
- scan_cnt  output  2  display digit index, 0..3.

## Operation
- pc_plus4 = pc + 32'd4, modulo 2^32. No carry out.
- branch_target = pc_plus4 + {imm_sext[29:0], 2'b00}, modulo 2^32. Negative immediates branch backward through two's-complement wrap.
- ALU opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0110 SUB (a − b)
  - 0111 SLT: signed a < b gives 32'd1, else 32'd0
  - 1100 NOR
  - every other code gives result 32'd0
- ADD and SUB wrap modulo 2^32. There is no overflow flag or trap.
- SLT compares as signed: 0x80000000 < 0x00000001 is true.
- alu_zero is derived from the final result, so any undefined opcode forces alu_zero = 1.
- Scan counter:
  - scan_cnt increments by 1 on each rising clk edge where scan_tick = 1.
  - It wraps from 3 to 0.
  - When scan_tick = 0, it holds.

## Timing
- pc_plus4, branch_target, alu_result and alu_zero are purely combinational. They settle in the same cycle as their inputs, with zero clock latency and no registers.
- Combinational outputs are unaffected by rst_n.
- scan_cnt is registered:
  - Assertion of rst_n = 0 clears it to 2'b00 immediately, independent of clk.
  - It stays 0 while rst_n is low, even if scan_tick pulses.
  - After rst_n deasserts, the first scan_tick-qualified edge gives 1.
- scan_tick high on consecutive cycles advances scan_cnt once per cycle.
- Reset during a scan_tick edge: reset wins and scan_cnt = 0.

## Structure
- Shared package mips_pkg holds the ALU opcode localparams: ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SUB, ALU_SLT, ALU_NOR. The control unit imports the same constants.
- One sub-module, alu32: the ALU and zero-flag logic.
- The adders and the scan counter are coded inline in mips_exec_arith.

## Test plan
- Adders: pc=0x00000010, imm_sext=0xFFFFFFFF -> pc_plus4=0x00000014, branch_target=0x00000010. pc=0xFFFFFFFC -> pc_plus4=0x00000000 (wrap).
- ALU logic ops: a=0xF0F0F0F0, b=0x0FF00FF0 ->
  - AND = 0x00F000F0
  - OR = 0xFFF0FFF0
  - XOR = 0xFF00FF00
  - NOR = 0x000F000F
  - alu_zero = 0 for all four.
- ALU arithmetic ops:
  - ADD 0xFFFFFFFF+1 = 0, alu_zero=1.
  - SUB 5−7 = 0xFFFFFFFE.
  - SLT a=0x80000000, b=1 -> 1. SLT a=1, b=0x80000000 -> 0.
- Undefined opcode: alu_op=1111 -> alu_result=0, alu_zero=1.
- Scan counter count and wrap: rst_n low -> scan_cnt=0 asynchronously. Release, then 5 scan_tick pulses -> sequence 1,2,3,0,1. Cycles without scan_tick hold the value.
- Reset mid-count: with scan_cnt=2, drop rst_n between clock edges -> scan_cnt=0 before the next edge. It stays 0 while rst_n is low, even with scan_tick asserted.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - ALU opcode constants shared by the execute stage and the control unit
package mips_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/mips_exec_arith_if.sv
// rtl/mips_exec_arith_if.sv - execute-stage operand/result bundle
interface mips_exec_arith_if;

    logic [31:0] pc;
    logic [31:0] imm_sext;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic        scan_tick;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [1:0]  scan_cnt;

    modport master (
        output pc, imm_sext, alu_a, alu_b, alu_op, scan_tick,
        input  pc_plus4, branch_target, alu_result, alu_zero, scan_cnt
    );

    modport slave (
        input  pc, imm_sext, alu_a, alu_b, alu_op, scan_tick,
        output pc_plus4, branch_target, alu_result, alu_zero, scan_cnt
    );

endinterface

// File: rtl/alu32.sv
// rtl/alu32.sv - 32-bit ALU with zero flag
module alu32
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = 32'd0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_XOR: result = a ^ b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {31'd0, $signed(a) < $signed(b)};
            ALU_NOR: result = ~(a | b);
            default: result = 32'd0;
        endcase
    end

    // Taken from the final result so undefined opcodes report zero.
    assign zero = (result == 32'd0);

endmodule

// File: rtl/mips_exec_arith.sv
// rtl/mips_exec_arith.sv - PC incrementer, branch adder, ALU and display scan counter
module mips_exec_arith (
    input  logic             clk,
    input  logic             rst_n,
    mips_exec_arith_if.slave bus
);

    logic [1:0] scan_cnt_q;

    assign bus.pc_plus4      = bus.pc + 32'd4;
    assign bus.branch_target = bus.pc_plus4 + (bus.imm_sext << 2);

    alu32 u_alu (
        .a      (bus.alu_a),
        .b      (bus.alu_b),
        .op     (bus.alu_op),
        .result (bus.alu_result),
        .zero   (bus.alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= 2'd0;
        end else if (bus.scan_tick) begin
            scan_cnt_q <= scan_cnt_q + 2'd1;
        end
    end

    assign bus.scan_cnt = scan_cnt_q;

endmodule

// File: tb/tb_mips_exec_arith.sv
// tb/tb_mips_exec_arith.sv - randomized and directed checks of mips_exec_arith
module tb_mips_exec_arith;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    bit   chk_en;
    int   model_cnt;

    mips_exec_arith_if bus ();

    mips_exec_arith u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a ^ b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12:   return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference counter: plain modulo-4 count of ticks seen while out of reset.
    always @(negedge rst_n) model_cnt = 0;
    always @(posedge clk) begin
        if (!rst_n) model_cnt = 0;
        else if (bus.scan_tick) model_cnt = (model_cnt + 1) % 4;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] r;
            r = ref_alu(bus.alu_a, bus.alu_b, bus.alu_op);
            check("pc_plus4", bus.pc_plus4, bus.pc + 32'd4);
            check("branch_target", bus.branch_target, bus.pc + 32'd4 + bus.imm_sext * 32'd4);
            check("alu_result", bus.alu_result, r);
            check("alu_zero", {31'd0, bus.alu_zero}, {31'd0, r == 32'd0});
            check("scan_cnt", {30'd0, bus.scan_cnt}, model_cnt[31:0]);
        end
    end

    task automatic set_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        bus.alu_a = a; bus.alu_b = b; bus.alu_op = op;
        #1;
    endtask

    task automatic step(input logic tick);
        @(posedge clk); #2;
        bus.scan_tick = tick;
    endtask

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [1:0] seq [5];
        checks = 0; failures = 0; chk_en = 1'b0; model_cnt = 0;
        rst_n = 1'b0;
        bus.pc = 32'h0; bus.imm_sext = 32'h0; bus.alu_a = 32'h0; bus.alu_b = 32'h0;
        bus.alu_op = 4'd0; bus.scan_tick = 1'b0;
        #1;
        check("reset_scan_cnt", {30'd0, bus.scan_cnt}, 32'd0);

        bus.pc = 32'h0000_0010; bus.imm_sext = 32'hFFFF_FFFF; #1;
        check("lit_pc_plus4", bus.pc_plus4, 32'h0000_0014);
        check("lit_branch_back", bus.branch_target, 32'h0000_0010);
        bus.pc = 32'hFFFF_FFFC; #1;
        check("lit_pc_wrap", bus.pc_plus4, 32'h0000_0000);

        set_alu(32'hF0F0F0F0, 32'h0FF00FF0, 4'b0000);
        check("lit_and", bus.alu_result, 32'h00F000F0);
        check("lit_and_zero", {31'd0, bus.alu_zero}, 32'd0);
        set_alu(32'hF0F0F0F0, 32'h0FF00FF0, 4'b0001);
        check("lit_or", bus.alu_result, 32'hFFF0FFF0);
        set_alu(32'hF0F0F0F0, 32'h0FF00FF0, 4'b0011);
        check("lit_xor", bus.alu_result, 32'hFF00FF00);
        set_alu(32'hF0F0F0F0, 32'h0FF00FF0, 4'b1100);
        check("lit_nor", bus.alu_result, 32'h000F000F);
        check("lit_nor_zero", {31'd0, bus.alu_zero}, 32'd0);
        set_alu(32'hFFFFFFFF, 32'd1, 4'b0010);
        check("lit_add_wrap", bus.alu_result, 32'd0);
        check("lit_add_zero", {31'd0, bus.alu_zero}, 32'd1);
        set_alu(32'd5, 32'd7, 4'b0110);
        check("lit_sub", bus.alu_result, 32'hFFFFFFFE);
        set_alu(32'h80000000, 32'd1, 4'b0111);
        check("lit_slt_true", bus.alu_result, 32'd1);
        set_alu(32'd1, 32'h80000000, 4'b0111);
        check("lit_slt_false", bus.alu_result, 32'd0);
        set_alu(32'h12345678, 32'h9ABCDEF0, 4'b1111);
        check("lit_undef", bus.alu_result, 32'd0);
        check("lit_undef_zero", {31'd0, bus.alu_zero}, 32'd1);

        // Counter stays cleared while held in reset even with ticks.
        bus.scan_tick = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("scan_in_reset", {30'd0, bus.scan_cnt}, 32'd0);
        bus.scan_tick = 1'b0;
        rst_n = 1'b1;
        chk_en = 1'b1;

        seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            step(1'b0);
            check("scan_seq", {30'd0, bus.scan_cnt}, {30'd0, seq[i]});
        end
        repeat (3) step(1'b0);
        check("scan_hold", {30'd0, bus.scan_cnt}, 32'd1);

        step(1'b1);
        step(1'b0);
        check("scan_at_two", {30'd0, bus.scan_cnt}, 32'd2);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("scan_async_clear", {30'd0, bus.scan_cnt}, 32'd0);
        bus.scan_tick = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("scan_hold_in_reset", {30'd0, bus.scan_cnt}, 32'd0);
        bus.scan_tick = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            bus.pc        = $urandom();
            bus.imm_sext  = ($urandom_range(0, 1) == 1) ? {{16{1'b1}}, 16'($urandom())}
                                                        : {16'd0, 16'($urandom())};
            bus.alu_a     = pick(int'($urandom_range(0, 7)));
            bus.alu_b     = ($urandom_range(0, 5) == 0) ? bus.alu_a : pick(int'($urandom_range(0, 7)));
            bus.alu_op    = 4'($urandom_range(0, 15));
            bus.scan_tick = 1'($urandom_range(0, 1));
            if (i == 200) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        @(posedge clk); #2;
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
